// File: rtl/axi_csr_buf.sv
// CSR slave for the AXI-Lite master engine: transfer configuration, write-data
// buffer, read-capture buffer, busy/done/overflow status and a done interrupt.
module axi_csr_buf #(
    parameter  int DEPTH  = 16,
    parameter  int ADDR_W = 8,
    localparam int LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sel,
    input  logic                  enable,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [31:0]           wdata,
    input  logic                  write,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  slverr,
    output logic [31:0]           address,
    output logic                  start,
    output logic [LEN_W-1:0]      len,
    output logic                  r_w,
    output logic [DEPTH*32-1:0]   data,
    output logic                  irq,
    input  logic                  tr_start,
    input  logic                  tr_complete,
    input  logic [31:0]           r_data,
    input  logic                  r_valid
);

    localparam int           IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0]   DEPTH_C = 7'(DEPTH);

    logic [31:0] wbuf [DEPTH];
    logic [31:0] rbuf [DEPTH];
    logic        irq_en;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [6:0]  rcount;

    logic        acc, locked;
    logic        is_ctrl, is_addr, is_stat, is_wbuf, is_rbuf, unmapped;
    logic        rd_err, wr_err, acc_err;
    logic [31:0] rd_val;
    logic        ctrl_wr_full, ctrl_wr_stop, addr_wr, wbuf_wr, stat_wr;
    logic [6:0]  ptr;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [28:0] req);
        if (req > 29'(DEPTH))
            return LEN_W'(DEPTH);
        else if (req == 29'd0)
            return LEN_W'(1);
        else
            return req[LEN_W-1:0];
    endfunction

    assign acc    = sel & enable & ~ready;
    assign locked = busy | start;

    assign is_ctrl  = (addr == ADDR_W'('h00));
    assign is_addr  = (addr == ADDR_W'('h01));
    assign is_stat  = (addr == ADDR_W'('h02));
    assign is_wbuf  = (addr >= ADDR_W'('h40)) && (addr < ADDR_W'('h40 + DEPTH));
    assign is_rbuf  = (addr >= ADDR_W'('h80)) && (addr < ADDR_W'('h80 + DEPTH));
    assign unmapped = ~(is_ctrl | is_addr | is_stat | is_wbuf | is_rbuf);

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (is_ctrl) begin
            rd_val[0]         = start;
            rd_val[1]         = r_w;
            rd_val[2+:LEN_W]  = len;
            rd_val[31]        = irq_en;
        end else if (is_addr) begin
            rd_val = address;
        end else if (is_stat) begin
            rd_val[0]    = busy;
            rd_val[1]    = done;
            rd_val[2]    = ovf;
            rd_val[8+:7] = rcount;
        end else if (is_wbuf) begin
            rd_val = wbuf[addr[IDX_W-1:0]];
        end else if (is_rbuf) begin
            rd_val = rbuf[addr[IDX_W-1:0]];
        end else begin
            rd_err = 1'b1;
        end
    end

    // A CTRL write that drops start is still honoured while locked.
    assign wr_err  = unmapped | (locked & ((is_ctrl & wdata[0]) | is_addr | is_wbuf));
    assign acc_err = write ? wr_err : rd_err;

    assign ctrl_wr_full = acc & write & is_ctrl & ~locked;
    assign ctrl_wr_stop = acc & write & is_ctrl & locked & ~wdata[0];
    assign addr_wr      = acc & write & is_addr & ~locked;
    assign wbuf_wr      = acc & write & is_wbuf & ~locked;
    assign stat_wr      = acc & write & is_stat;

    assign ptr = tr_start ? 7'd0 : rcount;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready   <= 1'b0;
            slverr  <= 1'b0;
            rdata   <= '0;
            start   <= 1'b0;
            r_w     <= 1'b0;
            len     <= '0;
            irq_en  <= 1'b0;
            address <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            rcount  <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                wbuf[i] <= '0;
                rbuf[i] <= '0;
            end
        end else begin
            ready  <= acc;
            slverr <= acc & acc_err;
            if (acc)
                rdata <= write ? 32'h0 : rd_val;

            if (ctrl_wr_full) begin
                r_w    <= wdata[1];
                len    <= clamp_len(wdata[30:2]);
                irq_en <= wdata[31];
            end else if (ctrl_wr_stop) begin
                irq_en <= wdata[31];
            end

            if (tr_start)
                start <= 1'b0;
            else if (ctrl_wr_full)
                start <= wdata[0];
            else if (ctrl_wr_stop)
                start <= 1'b0;

            if (addr_wr)
                address <= wdata;
            if (wbuf_wr)
                wbuf[addr[IDX_W-1:0]] <= wdata;

            if (tr_complete)
                busy <= 1'b0;
            else if (tr_start)
                busy <= 1'b1;

            // Hardware set beats tr_start clear beats software W1C.
            if (tr_complete)
                done <= 1'b1;
            else if (tr_start)
                done <= 1'b0;
            else if (stat_wr & wdata[1])
                done <= 1'b0;

            if (r_valid && ptr < DEPTH_C) begin
                rbuf[ptr[IDX_W-1:0]] <= r_data;
                rcount               <= ptr + 7'd1;
            end else if (tr_start) begin
                rcount <= '0;
            end

            if (r_valid && ptr >= DEPTH_C)
                ovf <= 1'b1;
            else if (tr_start)
                ovf <= 1'b0;
            else if (stat_wr & wdata[2])
                ovf <= 1'b0;

            irq <= done & irq_en;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_data
        assign data[32*g +: 32] = wbuf[g];
    end

endmodule

// File: tb/tb_axi_csr_buf.sv
// Directed bench for axi_csr_buf (DEPTH=16): register table plus transfer,
// overflow, lock, reset and access-timing sequences.
module tb_axi_csr_buf;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 sel, enable, write;
    logic [ADDR_W-1:0]    addr;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 ready, slverr;
    logic [31:0]          address;
    logic                 start;
    logic [LEN_W-1:0]     len;
    logic                 r_w;
    logic [DEPTH*32-1:0]  data;
    logic                 irq;
    logic                 tr_start, tr_complete;
    logic [31:0]          r_data;
    logic                 r_valid;

    int total = 0;
    int fails = 0;

    axi_csr_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .sel(sel), .enable(enable), .addr(addr),
        .wdata(wdata), .write(write), .rdata(rdata), .ready(ready), .slverr(slverr),
        .address(address), .start(start), .len(len), .r_w(r_w), .data(data),
        .irq(irq), .tr_start(tr_start), .tr_complete(tr_complete),
        .r_data(r_data), .r_valid(r_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where ready fell.
    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic err);
        int n;
        sel = 1'b1; enable = 1'b1; write = w; addr = a; wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 8);
        if (!ready) begin
            total++;
            fails++;
            $display("FAIL bus_timeout: got ready=0 expected ready=1 addr=%h", a);
        end
        rd  = rdata;
        err = slverr;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
        logic [31:0] d;
        logic        e;
        bus(1'b0, a, 32'h0, d, e);
        chk({name, "_rdata"}, d, exp_d);
        chk({name, "_slverr"}, 32'(e), 32'(exp_e));
    endtask

    task automatic wr_chk(input string name, input logic [7:0] a, input logic [31:0] d,
                          input logic exp_e);
        logic [31:0] r;
        logic        e;
        bus(1'b1, a, d, r, e);
        chk({name, "_slverr"}, 32'(e), 32'(exp_e));
    endtask

    task automatic pulse(input logic ts, input logic tc, input logic rv, input logic [31:0] rdv);
        tr_start = ts; tr_complete = tc; r_valid = rv; r_data = rdv;
        @(posedge clk); #1;
        tr_start = 1'b0; tr_complete = 1'b0; r_valid = 1'b0; r_data = 32'h0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [3:0]  rdy_exp;

        reset_n = 1'b0;
        sel = 1'b0; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        tr_start = 1'b0; tr_complete = 1'b0; r_data = '0; r_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted in the middle of an access with ready high
        bus(1'b1, 8'h01, 32'hDEAD_BEEF, d, e);
        bus(1'b1, 8'h00, 32'h8000_0043, d, e);
        chk("pre_reset_start", 32'(start), 32'd1);
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 8'h01;
        @(posedge clk); #1;
        chk("pre_reset_ready", 32'(ready), 32'd1);
        chk("pre_reset_rdata", rdata, 32'hDEAD_BEEF);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", 32'(ready), 32'd0);
        chk("rst_hold_rdata", rdata, 32'h0);
        sel = 1'b0; enable = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Register table: reset values, RW, clamping, decode errors, lock
        vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h01, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h02, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h40, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h80, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b1, 8'h01, 32'h0000_1000, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h01, 32'h0,         32'h0000_1000, 1'b0});
        vecs.push_back('{1'b1, 8'h43, 32'hCAFE_0003, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h43, 32'h0,         32'hCAFE_0003, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 32'h0000_00A0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0040, 1'b0});
        vecs.push_back('{1'b1, 8'h00, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h0000_0004, 1'b0});
        vecs.push_back('{1'b0, 8'h7F, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 8'h7F, 32'h5,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 8'h50, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 8'h90, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b0, 8'hC0, 32'h0,         32'h0,         1'b1});
        vecs.push_back('{1'b1, 8'h80, 32'h1111_1111, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h80, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b1, 8'h02, 32'hFFFF_FFFF, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h02, 32'h0,         32'h0,         1'b0});
        vecs.push_back('{1'b1, 8'h00, 32'h8000_0043, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 8'h00, 32'h0,         32'h8000_0043, 1'b0});
        vecs.push_back('{1'b1, 8'h01, 32'h0000_1234, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 8'h01, 32'h0,         32'h0000_1000, 1'b0});
        vecs.push_back('{1'b1, 8'h43, 32'h0000_0001, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 8'h43, 32'h0,         32'hCAFE_0003, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            bus(vecs[i].w, vecs[i].a, vecs[i].d, d, e);
            if (!vecs[i].w)
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].rd);
            chk($sformatf("vec%0d_slverr", i), 32'(e), 32'(vecs[i].err));
        end

        chk("out_start", 32'(start), 32'd1);
        chk("out_len", 32'(len), 32'd16);
        chk("out_r_w", 32'(r_w), 32'd1);
        chk("out_address", address, 32'h0000_1000);
        chk("out_data3", data[3*32 +: 32], 32'hCAFE_0003);

        // Transfer: accept, lock while busy, capture, completion, W1C
        pulse(1'b1, 1'b0, 1'b0, 32'h0);
        chk("xfer_start_clr", 32'(start), 32'd0);
        rd_chk("xfer_busy", 8'h02, 32'h0000_0001, 1'b0);
        wr_chk("lock_addr_wr", 8'h01, 32'h0000_1234, 1'b1);
        rd_chk("lock_addr_rd", 8'h01, 32'h0000_1000, 1'b0);
        rd_chk("lock_wbuf3_rd", 8'h43, 32'hCAFE_0003, 1'b0);
        wr_chk("lock_ctrl_stop", 8'h00, 32'h8000_0000, 1'b0);
        rd_chk("lock_ctrl_rd", 8'h00, 32'h8000_0042, 1'b0);

        for (int k = 0; k < 4; k++)
            pulse(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(k));
        for (int k = 0; k < 4; k++)
            rd_chk($sformatf("cap_rbuf%0d", k), 8'h80 + 8'(k), 32'hA0 + 32'(k), 1'b0);
        rd_chk("cap_status", 8'h02, 32'h0000_0401, 1'b0);

        pulse(1'b0, 1'b1, 1'b0, 32'h0);
        chk("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("done_status", 8'h02, 32'h0000_0402, 1'b0);
        wr_chk("w1c_done", 8'h02, 32'h0000_0002, 1'b0);
        chk("irq_clr", 32'(irq), 32'd0);
        rd_chk("w1c_status", 8'h02, 32'h0000_0400, 1'b0);

        // Overflow: first beat coincides with tr_start, DEPTH+2 beats total
        wr_chk("ovf_ctrl", 8'h00, 32'h8000_0041, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 32'hB0);
        for (int k = 1; k < DEPTH + 2; k++)
            pulse(1'b0, 1'b0, 1'b1, 32'hB0 + 32'(k));
        rd_chk("ovf_rbuf0", 8'h80, 32'h0000_00B0, 1'b0);
        rd_chk("ovf_rbuf_last", 8'h80 + 8'(DEPTH - 1), 32'hB0 + 32'(DEPTH - 1), 1'b0);
        rd_chk("ovf_status", 8'h02, 32'h0000_1005, 1'b0);
        wr_chk("w1c_ovf", 8'h02, 32'h0000_0004, 1'b0);
        rd_chk("w1c_ovf_status", 8'h02, 32'h0000_1001, 1'b0);

        // W1C of done in the same cycle as tr_complete: set wins
        sel = 1'b1; enable = 1'b1; write = 1'b1; addr = 8'h02; wdata = 32'h2;
        tr_complete = 1'b1;
        @(posedge clk); #1;
        tr_complete = 1'b0;
        chk("race_ready", 32'(ready), 32'd1);
        chk("race_slverr", 32'(slverr), 32'd0);
        sel = 1'b0; enable = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        rd_chk("race_status", 8'h02, 32'h0000_1002, 1'b0);
        chk("race_irq", 32'(irq), 32'd1);

        // sel & enable held: one accepted access every other cycle
        rdy_exp = 4'b1010;
        sel = 1'b1; enable = 1'b1; write = 1'b0; addr = 8'h01;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold_ready%0d", k), 32'(ready), 32'(rdy_exp[k]));
            @(posedge clk); #1;
        end
        sel = 1'b0; enable = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
        $finish;
    end

endmodule

// File: doc/axi_csr_buf.md
Name: axi_csr_buf

Overview:
- Parametrised successor to the single-channel AXI-Lite master CSR block.
- A peripheral-bus slave (sel/enable/write, one-cycle ready) holds transfer configuration, a DEPTH-entry write-data buffer and a DEPTH-entry read-capture buffer for the AXI-Lite master engine.
- Adds over the previous generation:
  - status register with busy/done/overflow flags
  - write-1-to-clear done
  - interrupt output
  - error response on unmapped or locked accesses
  - configuration lock while a transfer is in flight

Parameters:
DEPTH, 16, data/read buffer entries; legal 1..64
ADDR_W, 8, word-address width of the CSR bus; must be 8 or more
LEN_W, $clog2(DEPTH)+1, width of the beat-count field (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
sel  in  1  slave select
enable  in  1  access phase
addr  in  ADDR_W  word address
wdata  in  32  write data
write  in  1  1 = write, 0 = read
rdata  out  32  read data, valid with ready
ready  out  1  one-cycle access completion pulse
slverr  out  1  error flag, valid with ready
address  out  32  transfer base address
start  out  1  transfer request level
len  out  LEN_W  beat count
r_w  out  1  1 = engine read, 0 = engine write
data  out  DEPTH*32  flattened write buffer; entry i at [32i+:32]
irq  out  1  done & irq_en
tr_start  in  1  engine accepted request (pulse)
tr_complete  in  1  engine finished (pulse)
r_data  in  32  captured read beat
r_valid  in  1  r_data valid (pulse per beat)

Behaviour:
Reset:
- Asynchronous on reset_n low; all registers, buffers and outputs are 0.

Access timing:
- An access is accepted when sel & enable & !ready.
- ready and slverr are driven high for exactly the next cycle; rdata is updated that same cycle and holds its value otherwise.
- Back-to-back accesses therefore take at least 2 cycles each.

Register map (word addresses):
- 0x00 CTRL RW:
  - [0] start
  - [1] r_w
  - [2+:LEN_W] len; a written value > DEPTH is clamped to DEPTH, a written 0 is stored as 1
  - [31] irq_en
- 0x01 ADDR RW: 32-bit base address.
- 0x02 STATUS:
  - [0] busy RO
  - [1] done W1C
  - [2] ovf W1C
  - [8+:7] rcount RO
- 0x40 + i, i < DEPTH: WBUF[i] RW.
- 0x80 + i, i < DEPTH: RBUF[i] RO.
- Unmapped addresses and i >= DEPTH: ready with slverr=1, reads return 0, no state change.

Lock and error rules:
- While busy=1 or start=1, writes to CTRL, ADDR and WBUF complete with slverr=1 and are ignored.
- Exception: a CTRL write with wdata[0]=0 clears start and irq_en may still change.
- Writes to RBUF or to STATUS RO bits: slverr=0, no effect.

Transfer control:
- start: set by an accepted CTRL write with wdata[0]=1; cleared the cycle after tr_start.
- busy: set on tr_start, cleared on tr_complete.
- done: set on tr_complete.
  - A W1C in the same cycle loses; set wins.
  - tr_start and tr_complete in the same cycle: busy=0, done=1.
- tr_start also:
  - clears done, ovf and rcount
  - resets the capture pointer to 0

Read capture:
- Each r_valid writes r_data into RBUF[rcount] and increments rcount.
- At rcount == DEPTH, further beats are dropped, ovf is set and rcount saturates.
- r_valid in the same cycle as tr_start: pointer resets first, beat goes to entry 0, rcount = 1.

Outputs:
- irq is registered: irq = done & irq_en, updated one cycle after either changes.
- len, address, r_w and data are direct register outputs.

Test Plan:
- Reset: reset_n low mid-access with ready high -> ready, start, rdata and irq go to 0 immediately and stay 0; all registers read 0 after release.
- Config: write CTRL 0x8000_0043 (start=1, r_w=1, len=16), DEPTH=16 -> CTRL reads 0x8000_0043, start=1, len=16. Write len field 40 -> len reads 16.
- Lock: with busy=1, write ADDR 0x1234 -> slverr=1, ADDR unchanged. Read WBUF[3] -> slverr=0, correct data.
- Transfer: tr_start pulse -> start=0 and busy=1 next cycle. 4 r_valid beats 0xA0..0xA3 -> RBUF[0..3] = 0xA0..0xA3, rcount=4. tr_complete -> done=1, irq=1 one cycle later. Write STATUS 0x2 -> done=0, irq=0.
- Overflow: DEPTH+2 r_valid beats -> rcount=DEPTH, ovf=1, RBUF[DEPTH-1] holds beat DEPTH-1.
- Corner/error: read 0x7F -> slverr=1, rdata=0. W1C done coincident with tr_complete -> done=1. Hold sel&enable for 4 cycles -> ready pattern 0,1,0,1.
